jtframe_osd_keyenc: RTL
=======================

# jtframe_osd_keyenc

Parametrised OSD key encoder feeding the 8-bit `data_in` byte that the SPI `data_io` block returns to the menu firmware. It merges NJOY joystick words and priority-encodes directions/fire into 5-bit menu key codes, with auto-repeat. It detects a held OSD button combination and gates the whole byte behind a power-up countdown and a first-download flag. An external-byte mode covers boards whose firmware supplies its own OSD byte.

## Interface
Parameters:
- NJOY, 2, number of joystick words merged (1..4)
- JOYW, 12, bits per joystick word (≥5)
- COMBO, 12'h440, OSD combo mask over the merged word, default Start+C; must be nonzero
- HOLD, 4, cen ticks the combo must be held before OSD command asserts (≥1)
- OSDLEN, 8, minimum cen ticks the OSD command stays asserted once raised (≥1)
- PULSE, 4, cen ticks a key code is shown per press/repeat (≥1)
- DLY, 32, cen ticks of release gap after the first pulse (≥1)
- RPT, 8, cen ticks of release gap between repeats (≥1)
- CNTW, 16, power-up countdown width in clk cycles

Ports:
- clk, in, 1, system clock; single clock domain
- rst, in, 1, asynchronous active-high reset
- cen, in, 1, tick enable (line rate, e.g. hs); the FSM and counters advance only when cen=1
- joy_in, in, NJOY*JOYW, active-high joystick words; word n at [n*JOYW +: JOYW]
- ioctl_download, in, 1, download in progress from `data_io`
- ext_en, in, 1, 1 selects ext_osd as the output byte after gating
- ext_osd, in, 8, externally generated OSD byte
- dout, out, 8, byte to `data_io` `data_in`
- osd_cmd, out, 1, OSD command currently asserted (debug/status)

## Operation
- Merge: jm = OR of all NJOY words, registered every clk (1-cycle sample register).
- Key encode, priority low bit first:
  - jm[0] → 23 (right)
  - jm[1] → 27 (left)
  - jm[2] → 29 (down)
  - jm[3] → 30 (up)
  - jm[4] → 15 (return)
  - none → 5'h1f
- Repeat FSM, evaluated on cen only; kc = current encoded code:
  - IDLE: show 1f. If kc≠1f, go to ON with cnt=PULSE, first=1, latch kc.
  - ON: show the latched code. cnt decrements; when it reaches 0, go to WAIT with cnt=first?DLY:RPT, first←0.
  - WAIT: show 1f. cnt decrements; when it reaches 0, go to ON with cnt=PULSE.
  - Any state, kc=1f: go to IDLE on that tick.
  - Any state, kc≠1f and ≠ latched code: restart ON with first=1 and the new code. Release and change take priority over counter expiry.
- Combo: hcnt counts consecutive cen ticks with (jm & COMBO)==COMBO, saturating at HOLD; any tick without the full combo clears it.
  - osd_cmd rises when hcnt reaches HOLD; ocnt loads OSDLEN.
  - ocnt decrements each cen while asserted.
  - osd_cmd falls on the first cen where ocnt==0 and the combo is not fully held.
- Byte: cmd = osd_cmd ? 3'b011 : 3'b111; nb = {cmd, key}.
- Gating, registered every clk:
  - While countdown ≠ 0: countdown decrements each clk (not cen) and dout=8'hff.
  - After countdown: dout = !dwn_done ? 8'h3f : ext_en ? ext_osd : nb.
  - dwn_done is set by ioctl_download=1, sticky until rst.

## Timing
- Reset (async) values:
  - dout=8'hff, osd_cmd=0
  - FSM=IDLE, countdown=all ones, dwn_done=0
  - hcnt=ocnt=cnt=0, jm=0
- Countdown lasts 2^CNTW−1 clks after rst deasserts; dout first leaves ff on the next clk.
- Latency: joy_in change → jm next clk → FSM/combo update on the first cen after that → dout on the following clk.
- ext_osd/ext_en → dout: 1 clk.
- ioctl_download → dout change (post-countdown): 2 clks (dwn_done, then dout).
- A held key produces: PULSE ticks of code, DLY ticks of 1f, then a repeating cycle of PULSE ticks of code and RPT ticks of 1f.
- rst mid-operation: all state returns to reset values immediately; countdown and dwn_done restart.

## Test plan
- Reset, CNTW=4: dout=ff for 15 clks after rst falls, then 8'h3f; pulse ioctl_download → dout=8'hff (no cmd, no key) 2 clks later.
- Post-download, hold jm[3] (up) 60 cen: dout=8'hfe for 4 cen, 8'hff for 32, 8'hfe for 4, 8'hff for 8, repeating; release → 8'hff at the next cen.
- Hold jm[0] and jm[4] together: code 23 wins, dout=8'hf7; drop jm[0] mid-WAIT → immediate ON with code 15 (8'hef) for 4 cen.
- Hold bits 10 and 6 (split across joy 0 and joy 1): osd_cmd rises at the 4th cen, dout[7:5]=3'b011; release after 1 cen → stays asserted for 8 cen total; a combo break at the 3rd tick → no assert.
- ext_en=1, ext_osd=8'h5a after download: dout=8'h5a 1 clk later; during countdown dout stays ff.
- Assert rst mid-repeat: dout=ff and osd_cmd=0 immediately, and dwn_done is cleared (dout=8'h3f after the countdown).

Source files
------------

// File: rtl/jtframe_osd_keyenc.sv
// OSD key encoder: merges joystick words into menu key codes with auto-repeat,
// detects a held OSD combo, and gates the byte behind a power-up countdown and download flag.
module jtframe_osd_keyenc #(
    parameter int unsigned    NJOY   = 2,
    parameter int unsigned    JOYW   = 12,
    parameter logic [JOYW-1:0] COMBO = JOYW'(12'h440),
    parameter int unsigned    HOLD   = 4,
    parameter int unsigned    OSDLEN = 8,
    parameter int unsigned    PULSE  = 4,
    parameter int unsigned    DLY    = 32,
    parameter int unsigned    RPT    = 8,
    parameter int unsigned    CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [NJOY*JOYW-1:0] joy_in,
    input  logic                 ioctl_download,
    input  logic                 ext_en,
    input  logic [7:0]           ext_osd,
    output logic [7:0]           dout,
    output logic                 osd_cmd
);

    localparam int unsigned CMAX = (PULSE > DLY) ? ((PULSE > RPT) ? PULSE : RPT)
                                                 : ((DLY > RPT) ? DLY : RPT);
    localparam int unsigned CW = $clog2(CMAX + 1);
    localparam int unsigned HW = $clog2(HOLD + 1);
    localparam int unsigned OW = $clog2(OSDLEN + 1);
    localparam logic [4:0]  KNONE = 5'h1f;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_WAIT} state_t;

    logic [JOYW-1:0] w_or;
    logic [JOYW-1:0] r_jm;
    logic [4:0]      w_kc;
    logic            w_full;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic            r_first, w_first_nx;
    logic [4:0]      r_code, w_code_nx;

    logic [HW-1:0]   r_hcnt, w_hcnt_nx;
    logic [OW-1:0]   r_ocnt, w_ocnt_nx, w_odec;
    logic            r_osd, w_osd_nx;

    logic [CNTW-1:0] r_cd;
    logic            r_dwn;
    logic [7:0]      r_dout;
    logic [4:0]      w_key;
    logic [7:0]      w_nb;

    // OR of all joystick words
    always_comb begin
        w_or = '0;
        for (int n = 0; n < int'(NJOY); n++) begin
            w_or = w_or | joy_in[n*JOYW +: JOYW];
        end
    end

    // Lowest set direction/fire bit wins
    always_comb begin
        if      (r_jm[0]) w_kc = 5'd23;
        else if (r_jm[1]) w_kc = 5'd27;
        else if (r_jm[2]) w_kc = 5'd29;
        else if (r_jm[3]) w_kc = 5'd30;
        else if (r_jm[4]) w_kc = 5'd15;
        else              w_kc = KNONE;
    end

    assign w_full = (r_jm & COMBO) == COMBO;
    assign w_odec = (r_ocnt == '0) ? '0 : r_ocnt - OW'(1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_first_nx = r_first;
        w_code_nx  = r_code;
        w_hcnt_nx  = r_hcnt;
        w_ocnt_nx  = r_ocnt;
        w_osd_nx   = r_osd;
        if (cen) begin
            // Release and code change override counter expiry
            if (w_kc == KNONE) begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end else if (r_state == ST_IDLE || w_kc != r_code) begin
                w_state_nx = ST_ON;
                w_cnt_nx   = CW'(PULSE);
                w_first_nx = 1'b1;
                w_code_nx  = w_kc;
            end else begin
                case (r_state)
                    ST_ON: begin
                        if (r_cnt <= CW'(1)) begin
                            w_state_nx = ST_WAIT;
                            w_cnt_nx   = r_first ? CW'(DLY) : CW'(RPT);
                            w_first_nx = 1'b0;
                        end else begin
                            w_cnt_nx = r_cnt - CW'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (r_cnt <= CW'(1)) begin
                            w_state_nx = ST_ON;
                            w_cnt_nx   = CW'(PULSE);
                        end else begin
                            w_cnt_nx = r_cnt - CW'(1);
                        end
                    end
                    default: w_state_nx = ST_IDLE;
                endcase
            end

            if (!w_full)                  w_hcnt_nx = '0;
            else if (r_hcnt != HW'(HOLD)) w_hcnt_nx = r_hcnt + HW'(1);

            if (w_full && r_hcnt == HW'(HOLD - 1)) begin
                w_osd_nx  = 1'b1;
                w_ocnt_nx = OW'(OSDLEN);
            end else if (r_osd) begin
                w_ocnt_nx = w_odec;
                if (w_odec == '0 && !w_full) w_osd_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jm    <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_code  <= KNONE;
            r_hcnt  <= '0;
            r_ocnt  <= '0;
            r_osd   <= 1'b0;
        end else begin
            r_jm    <= w_or;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_first <= w_first_nx;
            r_code  <= w_code_nx;
            r_hcnt  <= w_hcnt_nx;
            r_ocnt  <= w_ocnt_nx;
            r_osd   <= w_osd_nx;
        end
    end

    assign w_key = (r_state == ST_ON) ? r_code : KNONE;
    assign w_nb  = {r_osd ? 3'b011 : 3'b111, w_key};

    // Output gating: power-up countdown, then download flag, then source select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cd   <= '1;
            r_dwn  <= 1'b0;
            r_dout <= 8'hff;
        end else begin
            if (ioctl_download) r_dwn <= 1'b1;
            if (r_cd != '0) begin
                r_cd   <= r_cd - CNTW'(1);
                r_dout <= 8'hff;
            end else if (!r_dwn) begin
                r_dout <= 8'h3f;
            end else if (ext_en) begin
                r_dout <= ext_osd;
            end else begin
                r_dout <= w_nb;
            end
        end
    end

    assign dout    = r_dout;
    assign osd_cmd = r_osd;

endmodule
